// File: rtl/led_pwm_fade_pkg.sv
// led_pwm_pkg: shared widths, limits and the perceptual gamma helper for led_pwm_fade
package led_pwm_pkg;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PCNT_MAX = 8'd254;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;
  typedef logic [DUTY_W-1:0] duty_t;
  // (d*d + 255) >> 8 keeps 0 and 255 fixed points while halving mid-scale
  function automatic duty_t gamma8(duty_t d);
    logic [2*DUTY_W-1:0] p;
    p = {8'd0, d} * {8'd0, d} + 16'd255;
    return p[2*DUTY_W-1:DUTY_W];
  endfunction
endpackage

// File: rtl/led_pwm_fade_if.sv
// led_pwm_fade_if: control inputs and LED drive outputs of the fading PWM stage
interface led_pwm_fade_if #(parameter int CH = 8);
  logic en;
  logic hold;
  logic [CH-1:0] led_in;
  logic [CH-1:0] pwm_out;
  logic period_start;
  logic busy;
  modport master(output en, hold, led_in, input pwm_out, period_start, busy);
  modport slave(input en, hold, led_in, output pwm_out, period_start, busy);
endinterface

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one channel's saturating fade register and registered PWM compare.
// Define LED_PWM_GAMMA_EN to apply perceptual correction to the compared duty.
module led_pwm_chan import led_pwm_pkg::*; #(
  parameter logic [7:0] FADE_STEP = 8'h10
) (
  input  logic  CLK,
  input  logic  RST_X,
  input  logic  en_i,
  input  logic  hold_i,
  input  logic  fade_i,
  input  duty_t pcnt_i,
  input  logic  tgt_i,
  output logic  pwm_o,
  output logic  mismatch_o
);
  duty_t duty_q, duty_d, duty_eff;
  logic [DUTY_W:0] up;
  logic pwm_d;
`ifdef LED_PWM_GAMMA_EN
  assign duty_eff = gamma8(duty_q);
`else
  assign duty_eff = duty_q;
`endif
  always_comb begin
    up = {1'b0, duty_q} + {1'b0, FADE_STEP};
    duty_d = !en_i ? '0 :
             !(fade_i && !hold_i) ? duty_q :
             tgt_i ? (up[DUTY_W] ? DUTY_MAX : up[DUTY_W-1:0]) :
             (duty_q < FADE_STEP ? '0 : duty_q - FADE_STEP);
    pwm_d = en_i && (pcnt_i < duty_eff);
    mismatch_o = duty_q != (tgt_i ? DUTY_MAX : '0);
  end
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      duty_q <= '0;
      pwm_o <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_o <= pwm_d;
    end
  end
endmodule

// File: rtl/led_pwm_fade.sv
// led_pwm_fade: per-channel fading 8-bit PWM LED driver with period-aligned duty updates.
// Define LED_PWM_GAMMA_EN to enable perceptual gamma correction in every channel.
module led_pwm_fade import led_pwm_pkg::*; #(
  parameter int CH = 8,
  parameter int PRESCALE = 16,
  parameter int FADE_DIV = 4,
  parameter logic [7:0] FADE_STEP = 8'h10
) (
  input logic CLK,
  input logic RST_X,
  led_pwm_fade_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int FW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  logic [PW-1:0] pre_q, pre_d;
  duty_t pcnt_q, pcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic ps_q, ps_d, tick, wrap, fade;
  logic [CH-1:0] pwm, mismatch;
  // fade coincides with the pcnt wrap so a new duty always governs a full period
  always_comb begin
    tick = bus.en && pre_q == PW'(PRESCALE - 1);
    wrap = tick && pcnt_q == PCNT_MAX;
    fade = wrap && fcnt_q == FW'(FADE_DIV - 1);
    pre_d = !bus.en || tick ? '0 : pre_q + 1'b1;
    pcnt_d = !bus.en || wrap ? '0 : tick ? pcnt_q + 1'b1 : pcnt_q;
    fcnt_d = !bus.en || fade ? '0 : wrap ? fcnt_q + 1'b1 : fcnt_q;
    ps_d = wrap;
  end
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      pre_q <= '0;
      pcnt_q <= '0;
      fcnt_q <= '0;
      ps_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
      ps_q <= ps_d;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_pwm_chan #(.FADE_STEP(FADE_STEP)) u_ch (
      .CLK(CLK),
      .RST_X(RST_X),
      .en_i(bus.en),
      .hold_i(bus.hold),
      .fade_i(fade),
      .pcnt_i(pcnt_q),
      .tgt_i(bus.led_in[i]),
      .pwm_o(pwm[i]),
      .mismatch_o(mismatch[i])
    );
  end
  assign bus.pwm_out = pwm;
  assign bus.period_start = ps_q;
  assign bus.busy = |mismatch;
endmodule

// File: doc/led_pwm_fade.md
# led_pwm_fade

Output stage directly downstream of the LED pattern block: consumes its per-channel on/off vector and drives the physical LED pins with 8-bit PWM.
- Each channel ramps its brightness toward full-on or full-off instead of switching hard.
- Duty changes are applied only at PWM period boundaries, so outputs are glitch-free.
- Raises `busy` while any channel is still fading.

## Interface
Parameters:
- `CH`, 8, number of LED channels
- `PRESCALE`, 16, CLK cycles per PWM counter tick (≥1)
- `FADE_DIV`, 4, PWM periods per fade step (≥1)
- `FADE_STEP`, 8'h10, duty increment/decrement per fade step (1..255)

Ports:
- `CLK` in 1 — clock; one clock domain only
- `RST_X` in 1 — reset, asynchronous, active-low
- `en` in 1 — block enable
- `hold` in 1 — freeze all duty values; PWM keeps running
- `led_in` in CH — on/off targets from the LED pattern stage; bit=1 → target 255, bit=0 → target 0
- `pwm_out` out CH — registered PWM drive to pins
- `period_start` out 1 — one-cycle pulse at each PWM period start
- `busy` out 1 — high while any channel duty ≠ its current target

## Operation
- Prescaler `pre`, range 0..PRESCALE-1.
  - `tick` = `en` && `pre`==PRESCALE-1; `pre` wraps to 0 on tick.
- PWM counter `pcnt`, range 0..254, advances on tick; 254 wraps to 0. Period = 255 ticks.
- `period_start` is registered; it pulses in the cycle after the tick that wraps `pcnt` to 0.
- Fade divider `fcnt`, range 0..FADE_DIV-1.
  - Advances on each wrap of `pcnt` to 0.
  - `fade` strobe fires when `fcnt`==FADE_DIV-1 at that wrap; `fcnt` then returns to 0.
- On `fade`, when `hold`=0, each channel moves `duty[i]` toward target by FADE_STEP, saturating exactly at target:
  - Rising: `duty` = min(`duty`+FADE_STEP, 255), using 9-bit intermediate.
  - Falling: `duty` = max(`duty`-FADE_STEP, 0), no wrap.
- Target is sampled from `led_in` only at the `fade` strobe. Changes to `led_in` between strobes have no effect until the next strobe.
- `pwm_out[i]` <= (`pcnt` < `duty_eff[i]`):
  - duty 0 → constant low
  - duty 255 → constant high
- `busy` = OR over channels of (`duty[i]` ≠ (`led_in[i]` ? 255 : 0)). Combinational from registers and the live `led_in`.
- `en`=0:
  - `pre`, `pcnt`, `fcnt` and all `duty` are cleared synchronously.
  - `pwm_out` goes to 0 on the next cycle.
  - `period_start` stays 0.
- `en` rising: restart from a clean period. First `period_start` pulse occurs after 255×PRESCALE cycles.
- `hold`=1 on a fade strobe: that strobe is consumed with no duty change. `fcnt` still advances.

## Timing
- Reset (RST_X low, asynchronous): `pwm_out`=0, `period_start`=0, all counters and `duty`=0. `busy` then reflects `led_in` immediately.
- `pwm_out` latency: one CLK after the `pcnt` value that decides it.
- Duty update lands in the same cycle as the `pcnt` wrap, so a new duty governs a whole period. No partial periods.
- Ramp time 0→255 = ceil(255/FADE_STEP) fade strobes = ceil(255/FADE_STEP)×FADE_DIV×255×PRESCALE cycles.
- Reset asserted mid-ramp: everything returns to 0 immediately. No state is preserved.
- `hold` and `fade` in the same cycle: `hold` wins. `en`=0 overrides `hold`.

## Configuration
- `LED_PWM_GAMMA_EN` defined: perceptual correction `duty_eff` = (`duty`×`duty` + 255) >> 8. This maps 0→0, 1→1, 128→64, 255→255. One 8×8 multiply per channel, combinational.
- Undefined: `duty_eff` = `duty`. No multiplier is generated.
- `duty`, `busy` and fade behaviour are identical in both builds.

## Structure
- Package `led_pwm_pkg`:
  - `DUTY_W`=8
  - `PCNT_MAX`=8'd254
  - `DUTY_MAX`=8'd255
  - typedef `duty_t` (logic [7:0])
  - function `gamma8(duty_t)` used under the macro
- Sub-module `led_pwm_chan`, instantiated CH times:
  - Holds one `duty` register, saturating step logic, optional gamma, and the `pwm_out` compare flop.
  - Inputs: `pcnt`, `fade`, `hold`, `en`, target bit.
  - Outputs: `pwm_out` bit, `mismatch` bit.
- Top-level holds the prescaler, `pcnt`, `fcnt` and the `busy` OR-reduce.

## Test plan
Bench parameters: PRESCALE=1, FADE_DIV=1, FADE_STEP=8'h40.
- Reset with `led_in`=8'h00, `en`=1 → `pwm_out`=0 constantly; `busy`=0; `period_start` pulses every 255 cycles.
- `led_in`=8'h01 → `duty[0]` steps 0→64→128→192→255 over 4 strobes. `busy` clears after the 4th strobe. At duty 64, `pwm_out[0]` is high exactly 64 of 255 cycles (no gamma).
- Ramp to 255, then `led_in`=8'h00 → duty steps 255→191→127→63→0, never wrapping below 0. `pwm_out[0]` is low for the full period after the final step.
- `hold`=1 across two strobes during a ramp at duty 128 → duty stays 128. After `hold` drops, the next strobe gives 192.
- Drive RST_X low mid-period with duty 192 → `pwm_out` goes to 0 asynchronously. After release, the first `period_start` comes 255 cycles later.
- With `LED_PWM_GAMMA_EN` and duty 128 → `pwm_out` high for 64 cycles per period. `en`=0 mid-period → `pwm_out`=0 the next cycle.
